// File: rtl/pcm_capture_if.sv
// Output sample stream of pcm_capture: FIFO head word {ch, data, last} with valid/ready handshake.
interface pcm_capture_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, out_ch, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_ch, out_last, out_valid, output out_ready);
endinterface

// File: rtl/pcm_capture.sv
// Decimated multi-channel PCM capture into a small FIFO; a word is visible one clock after its push.
// A full FIFO with no pop drops the word and sets sticky overflow; capture timing never stalls.
module pcm_capture #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int DECIM    = 1131,
  parameter int DEPTH    = 16,
  parameter int SETTLE_W = 20,
  parameter int COUNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SETTLE_W-1:0]       settle_cycles,
  input  logic [COUNT_W-1:0]        sample_count,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  pcm_capture_if.master             out_if,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FLUSH} state_t;
  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] dat;
    logic             last;
  } word_t;

  state_t                    state;
  logic                      init_q;
  logic [SETTLE_W-1:0]       settle_q, settle_cnt;
  logic [COUNT_W-1:0]        count_q, frame_cnt;
  logic [CHANNELS-1:0]       mask_q, pend_q;
  logic [DEC_W-1:0]          dec_cnt;
  logic [CHANNELS*WIDTH-1:0] frame_q;

  word_t                     mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  word_t                     head;

  logic                      frame_start, has_word, frame_end, final_frame;
  logic [CHANNELS-1:0]       cur_pend, rest;
  logic [CHANNELS*WIDTH-1:0] cur_frame;
  logic [CH_W-1:0]           sel_ch;
  word_t                     push_word;
  logic                      fifo_empty, fifo_full, pop, push_req, push_ok, drop;

  // Slot 0 of a frame serialises straight from live data with the full mask; later slots drain pend_q.
  assign frame_start = (dec_cnt == '0);
  assign cur_pend    = frame_start ? mask_q : pend_q;
  assign cur_frame   = frame_start ? ch_data : frame_q;

  always_comb begin
    sel_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (cur_pend[i]) sel_ch = CH_W'(i);
  end

  assign rest        = cur_pend & ~(CHANNELS'(1) << sel_ch);
  assign has_word    = |cur_pend;
  assign frame_end   = (frame_start || has_word) && (rest == '0);
  assign final_frame = (frame_cnt == count_q - COUNT_W'(1));

  assign push_word.ch   = sel_ch;
  assign push_word.dat  = cur_frame[int'(sel_ch)*WIDTH +: WIDTH];
  assign push_word.last = final_frame && (rest == '0);

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
  assign pop        = !fifo_empty && out_if.out_ready;
  assign push_req   = (state == CAPTURE) && has_word && !abort;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign head              = mem[rd_ptr];
  assign out_if.out_valid  = !fifo_empty;
  assign out_if.out_data   = fifo_empty ? '0 : head.dat;
  assign out_if.out_ch     = fifo_empty ? '0 : head.ch;
  assign out_if.out_last   = !fifo_empty && head.last;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      init_q     <= 1'b0;
      settle_q   <= '0;
      settle_cnt <= '0;
      count_q    <= '0;
      frame_cnt  <= '0;
      mask_q     <= '0;
      pend_q     <= '0;
      dec_cnt    <= '0;
      frame_q    <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      done   <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start && init_q) begin
            settle_q   <= settle_cycles;
            count_q    <= sample_count;
            mask_q     <= ch_mask;
            overflow   <= 1'b0;
            settle_cnt <= '0;
            frame_cnt  <= '0;
            dec_cnt    <= '0;
            pend_q     <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == settle_q) state <= (count_q == '0) ? FLUSH : CAPTURE;
            else                        settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
          CAPTURE: begin
            if (frame_start) frame_q <= ch_data;
            pend_q  <= rest;
            dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);
            if (frame_end) begin
              if (final_frame) state <= FLUSH;
              else             frame_cnt <= frame_cnt + COUNT_W'(1);
            end
          end
          FLUSH: if (fifo_empty) begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
